// File: rtl/ip_packet_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ip_packet_tx                                                 |
// | Description : Wraps one accelerator result in an Ethernet II + IPv4 frame  |
// |               and streams it byte-wide to the MAC TX AXI-Stream port.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ip_packet_tx #(
   parameter int         RESULT_BYTES    = 1,
   parameter int         MIN_FRAME_BYTES = 60,
   parameter logic [7:0] IP_PROTOCOL     = 8'hFD,
   parameter logic [7:0] IP_TTL          = 8'd64
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic [0:31]               ACCELERATOR_IP_ADDRESS,
   input  logic [0:47]               ACCELERATOR_MAC_ADDRESS,
   input  logic [0:RESULT_BYTES*8-1] RESULT_DATA,
   input  logic [0:31]               DST_IP_ADDRESS,
   input  logic [0:47]               DST_MAC_ADDRESS,
   input  logic                      RESULT_VALID,
   output logic                      RESULT_READY,
   output logic [7:0]                MAC_DATA_IN,
   output logic                      MAC_DATA_VALID,
   output logic                      MAC_DATA_LAST,
   input  logic                      MAC_DATA_READY,
   output logic                      TX_BUSY
);
   localparam int          HDR_BYTES    = 34;
   localparam int          BODY_BYTES   = HDR_BYTES + RESULT_BYTES;
   localparam int          FRAME_BYTES  = (BODY_BYTES > MIN_FRAME_BYTES) ? BODY_BYTES : MIN_FRAME_BYTES;
   localparam logic [15:0] HDR_LAST     = 16'(HDR_BYTES - 1);
   localparam logic [15:0] DATA_LAST    = 16'(BODY_BYTES - 1);
   localparam logic [15:0] FRAME_LAST   = 16'(FRAME_BYTES - 1);
   localparam logic [15:0] IP_TOTAL_LEN = 16'(20 + RESULT_BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECKSUM, S_SEND_HDR, S_SEND_DATA, S_SEND_PAD
   } state_t;

   state_t                    state_q,    state_d;
   logic [0:RESULT_BYTES*8-1] result_q,   result_d;
   logic [0:31]               dst_ip_q,   dst_ip_d;
   logic [0:47]               dst_mac_q,  dst_mac_d;
   logic [0:31]               src_ip_q,   src_ip_d;
   logic [0:47]               src_mac_q,  src_mac_d;
   logic [15:0]               acc_q,      acc_d;
   logic [15:0]               csum_q,     csum_d;
   logic [3:0]                word_idx_q, word_idx_d;
   logic [15:0]               bcnt_q,     bcnt_d;
   logic                      tx_valid_q, tx_valid_d;
   logic                      tx_last_q,  tx_last_d;
   logic [7:0]                tx_data_q,  tx_data_d;

   logic [15:0]               ck_word;
   logic [16:0]               sum17;
   logic [15:0]               acc_next;
   logic [0:BODY_BYTES*8-1]   frame_vec;
   logic [15:0]               nxt_idx;
   logic [7:0]                nxt_byte;

   always_comb begin
      case (word_idx_q)
         4'd0:    ck_word = 16'h4500;
         4'd1:    ck_word = IP_TOTAL_LEN;
         4'd3:    ck_word = 16'h4000;
         4'd4:    ck_word = {IP_TTL, IP_PROTOCOL};
         4'd6:    ck_word = src_ip_q[0:15];
         4'd7:    ck_word = src_ip_q[16:31];
         4'd8:    ck_word = dst_ip_q[0:15];
         4'd9:    ck_word = dst_ip_q[16:31];
         default: ck_word = 16'h0000;  // ID word and the checksum slot itself
      endcase
      sum17    = {1'b0, acc_q} + {1'b0, ck_word};
      acc_next = sum17[15:0] + {15'd0, sum17[16]};
   end

   // Everything up to the end of the payload; pad bytes fall through to zero.
   always_comb begin
      frame_vec = {dst_mac_q, src_mac_q, 16'h0800, 16'h4500, IP_TOTAL_LEN,
                   16'h0000, 16'h4000, IP_TTL, IP_PROTOCOL, csum_q,
                   src_ip_q, dst_ip_q, result_q};
      nxt_idx   = (state_q == S_CHECKSUM) ? 16'd0 : bcnt_q + 16'd1;
      nxt_byte  = 8'h00;
      for (int i = 0; i < BODY_BYTES; i++) begin
         if (nxt_idx == 16'(i)) nxt_byte = frame_vec[i*8 +: 8];
      end
   end

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      dst_ip_d   = dst_ip_q;
      dst_mac_d  = dst_mac_q;
      src_ip_d   = src_ip_q;
      src_mac_d  = src_mac_q;
      acc_d      = acc_q;
      csum_d     = csum_q;
      word_idx_d = word_idx_q;
      bcnt_d     = bcnt_q;
      tx_valid_d = tx_valid_q;
      tx_last_d  = tx_last_q;
      tx_data_d  = tx_data_q;
      case (state_q)
         S_IDLE: begin
            if (RESULT_VALID) begin
               result_d   = RESULT_DATA;
               dst_ip_d   = DST_IP_ADDRESS;
               dst_mac_d  = DST_MAC_ADDRESS;
               src_ip_d   = ACCELERATOR_IP_ADDRESS;
               src_mac_d  = ACCELERATOR_MAC_ADDRESS;
               acc_d      = 16'd0;
               word_idx_d = 4'd0;
               state_d    = S_CHECKSUM;
            end
         end
         S_CHECKSUM: begin
            acc_d      = acc_next;
            word_idx_d = word_idx_q + 4'd1;
            if (word_idx_q == 4'd9) begin
               csum_d     = ~acc_next;
               bcnt_d     = 16'd0;
               tx_valid_d = 1'b1;
               tx_data_d  = nxt_byte;
               tx_last_d  = (FRAME_LAST == 16'd0);
               state_d    = S_SEND_HDR;
            end
         end
         S_SEND_HDR, S_SEND_DATA, S_SEND_PAD: begin
            if (tx_valid_q && MAC_DATA_READY) begin
               bcnt_d = bcnt_q + 16'd1;
               if (bcnt_q == FRAME_LAST) begin
                  tx_valid_d = 1'b0;
                  tx_last_d  = 1'b0;
                  tx_data_d  = 8'h00;
                  state_d    = S_IDLE;
               end else begin
                  tx_data_d = nxt_byte;
                  tx_last_d = (nxt_idx == FRAME_LAST);
                  if (state_q == S_SEND_HDR && bcnt_q == HDR_LAST)
                     state_d = S_SEND_DATA;
                  else if (state_q == S_SEND_DATA && bcnt_q == DATA_LAST)
                     state_d = S_SEND_PAD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q    <= S_IDLE;
         result_q   <= '0;
         dst_ip_q   <= '0;
         dst_mac_q  <= '0;
         src_ip_q   <= '0;
         src_mac_q  <= '0;
         acc_q      <= '0;
         csum_q     <= '0;
         word_idx_q <= '0;
         bcnt_q     <= '0;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         dst_ip_q   <= dst_ip_d;
         dst_mac_q  <= dst_mac_d;
         src_ip_q   <= src_ip_d;
         src_mac_q  <= src_mac_d;
         acc_q      <= acc_d;
         csum_q     <= csum_d;
         word_idx_q <= word_idx_d;
         bcnt_q     <= bcnt_d;
         tx_valid_q <= tx_valid_d;
         tx_last_q  <= tx_last_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign RESULT_READY   = (state_q == S_IDLE);
   assign TX_BUSY        = (state_q != S_IDLE);
   assign MAC_DATA_IN    = tx_data_q;
   assign MAC_DATA_VALID = tx_valid_q;
   assign MAC_DATA_LAST  = tx_last_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_packet_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ip_packet_tx                                              |
// | Description : Directed self-checking bench for ip_packet_tx (1- and 30-    |
// |               byte payload instances).                                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ip_packet_tx;
   localparam logic [0:31] ACC_IP  = 32'hC0A8010A;
   localparam logic [0:47] ACC_MAC = 48'h020000AABBCC;
   localparam logic [0:31] IP_A    = 32'hC0A80101;
   localparam logic [0:31] IP_B    = 32'hC0A80102;
   localparam logic [0:47] MAC_A   = 48'h0A0B0C0D0E0F;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:31] acc_ip;
   logic [0:47] acc_mac;
   logic [0:7]  res1;
   logic [0:239] res2;
   logic [0:31] dip  [2];
   logic [0:47] dmac [2];
   logic        rv   [2];
   logic        rdy  [2];
   logic        mv   [2];
   logic        ml   [2];
   logic        mr   [2];
   logic        busy [2];
   logic [7:0]  md   [2];

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  got [$];
   logic [7:0]  exp_f [$];
   logic [7:0]  pay [$];
   int          first_k, last_k;
   bit          aborted;

   always #5 clk = ~clk;

   ip_packet_tx #(.RESULT_BYTES(1)) u_dut1 (
      .ACLK(clk), .ARESET(rst),
      .ACCELERATOR_IP_ADDRESS(acc_ip), .ACCELERATOR_MAC_ADDRESS(acc_mac),
      .RESULT_DATA(res1), .DST_IP_ADDRESS(dip[0]), .DST_MAC_ADDRESS(dmac[0]),
      .RESULT_VALID(rv[0]), .RESULT_READY(rdy[0]),
      .MAC_DATA_IN(md[0]), .MAC_DATA_VALID(mv[0]), .MAC_DATA_LAST(ml[0]),
      .MAC_DATA_READY(mr[0]), .TX_BUSY(busy[0])
   );

   ip_packet_tx #(.RESULT_BYTES(30)) u_dut30 (
      .ACLK(clk), .ARESET(rst),
      .ACCELERATOR_IP_ADDRESS(acc_ip), .ACCELERATOR_MAC_ADDRESS(acc_mac),
      .RESULT_DATA(res2), .DST_IP_ADDRESS(dip[1]), .DST_MAC_ADDRESS(dmac[1]),
      .RESULT_VALID(rv[1]), .RESULT_READY(rdy[1]),
      .MAC_DATA_IN(md[1]), .MAC_DATA_VALID(mv[1]), .MAC_DATA_LAST(ml[1]),
      .MAC_DATA_READY(mr[1]), .TX_BUSY(busy[1])
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] gb(input int i);
      return (i < got.size()) ? got[i] : 8'hxx;
   endfunction

   // Reference frame: header, one's-complement checksum folded from a wide sum, payload, pad.
   function automatic void build(input int rb, input logic [0:47] dm, input logic [0:31] di,
                                 input logic [7:0] p [$], output logic [7:0] f [$]);
      logic [15:0] tl;
      logic [15:0] ck;
      int unsigned s;
      f.delete();
      for (int i = 0; i < 6; i++) f.push_back(dm[i*8 +: 8]);
      for (int i = 0; i < 6; i++) f.push_back(ACC_MAC[i*8 +: 8]);
      tl = 16'(20 + rb);
      f.push_back(8'h08); f.push_back(8'h00); f.push_back(8'h45); f.push_back(8'h00);
      f.push_back(tl[15:8]); f.push_back(tl[7:0]);
      f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h40); f.push_back(8'h00);
      f.push_back(8'd64); f.push_back(8'hFD); f.push_back(8'h00); f.push_back(8'h00);
      for (int i = 0; i < 4; i++) f.push_back(ACC_IP[i*8 +: 8]);
      for (int i = 0; i < 4; i++) f.push_back(di[i*8 +: 8]);
      s = 0;
      for (int i = 14; i < 34; i += 2) s += {16'h0000, f[i], f[i+1]};
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      ck = ~s[15:0];
      f[24] = ck[15:8];
      f[25] = ck[7:0];
      foreach (p[i]) f.push_back(p[i]);
      while (f.size() < 60) f.push_back(8'h00);
   endfunction

   task automatic cmp_frame(input string tag);
      int nbad = 0;
      check({tag, "_len"}, 64'(got.size()), 64'(exp_f.size()));
      for (int i = 0; i < exp_f.size(); i++) if (gb(i) !== exp_f[i]) nbad++;
      check({tag, "_bytes_bad"}, 64'(nbad), 64'd0);
   endtask

   task automatic wait_accept(input int d);
      int n = 0;
      while (!rdy[d] && n < 200) begin @(posedge clk); #1; n++; end
      check("accept_wait", 64'(n < 200), 64'd1);
   endtask

   // Called at the sample point of the handshake cycle; k counts cycles after it.
   task automatic collect(input int d, input bit bp, input bit iso, input bit keep,
                          input logic [0:31] new_dip, input int abort_at);
      bit stalled = 0, done = 0, dropped = 0;
      logic [7:0] pd = 8'h00;
      logic pl = 1'b0;
      got.delete();
      first_k = -1; last_k = -1; aborted = 0;
      for (int k = 1; k <= 2000 && !done; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            if (keep) dip[d] = new_dip; else rv[d] = 1'b0;
            check("ready_low", 64'(rdy[d]), 64'd0);
            check("busy_high", 64'(busy[d]), 64'd1);
         end
         if (iso) begin
            res1 = 8'($urandom);
            dip[d] = $urandom;
            dmac[d] = {16'($urandom), $urandom};
         end
         if (stalled) begin
            check("stall_data", 64'(md[d]), 64'(pd));
            check("stall_last", 64'(ml[d]), 64'(pl));
            check("stall_valid", 64'(mv[d]), 64'd1);
         end
         if (mv[d] && first_k < 0) first_k = k;
         if (first_k >= 0 && !dropped) begin
            check("valid_held", 64'(mv[d]), 64'd1);
            if (!mv[d]) dropped = 1;
         end
         if (abort_at >= 0 && mv[d] && got.size() == abort_at) begin
            rst = 1'b1;
            rv[d] = 1'b1;
            @(posedge clk); #1;
            check("rst_valid", 64'(mv[d]), 64'd0);
            check("rst_last", 64'(ml[d]), 64'd0);
            check("rst_ready", 64'(rdy[d]), 64'd1);
            rst = 1'b0;
            aborted = 1;
            return;
         end
         mr[d] = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (mv[d] && mr[d]) begin
            got.push_back(md[d]);
            if (ml[d]) begin last_k = k; done = 1; end
         end
         stalled = mv[d] && !mr[d];
         pd = md[d];
         pl = ml[d];
      end
      check("frame_done", 64'(done), 64'd1);
      @(posedge clk); #1;
      check("ready_after", 64'(rdy[d]), 64'd1);
   endtask

   initial begin
      int nz;
      rst = 1'b1;
      acc_ip = ACC_IP; acc_mac = ACC_MAC;
      res1 = 8'h07;
      for (int i = 0; i < 30; i++) res2[i*8 +: 8] = 8'(i + 1);
      for (int d = 0; d < 2; d++) begin
         dip[d] = IP_A; dmac[d] = MAC_A; rv[d] = 1'b0; mr[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_ready", 64'(rdy[d]), 64'd1);
         check("rst_valid", 64'(mv[d]), 64'd0);
         check("rst_last", 64'(ml[d]), 64'd0);
         check("rst_data", 64'(md[d]), 64'd0);
         check("rst_busy", 64'(busy[d]), 64'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic 60-byte frame
      pay = {8'h07};
      build(1, MAC_A, IP_A, pay, exp_f);
      rv[0] = 1'b1; wait_accept(0);
      collect(0, 0, 0, 0, IP_A, -1);
      check("basic_first_k", 64'(first_k), 64'd11);
      check("basic_last_k", 64'(last_k), 64'd70);
      check("basic_b12", 64'(gb(12)), 64'h08);
      check("basic_b13", 64'(gb(13)), 64'h00);
      check("basic_b16", 64'(gb(16)), 64'h00);
      check("basic_b17", 64'(gb(17)), 64'h15);
      check("basic_ck_hi", 64'(gb(24)), 64'hB6);
      check("basic_ck_lo", 64'(gb(25)), 64'h90);
      check("basic_b34", 64'(gb(34)), 64'h07);
      nz = 0;
      for (int i = 35; i < 60; i++) if (gb(i) !== 8'h00) nz++;
      check("basic_pad_nonzero", 64'(nz), 64'd0);
      cmp_frame("basic");

      // Backpressure
      rv[0] = 1'b1; wait_accept(0);
      collect(0, 1, 0, 0, IP_A, -1);
      cmp_frame("bp");

      // 30-byte payload, no padding
      pay.delete();
      for (int i = 0; i < 30; i++) pay.push_back(8'(i + 1));
      build(30, MAC_A, IP_A, pay, exp_f);
      rv[1] = 1'b1; wait_accept(1);
      collect(1, 0, 0, 0, IP_A, -1);
      check("np_len_lo", 64'(gb(17)), 64'h32);
      check("np_ck_hi", 64'(gb(24)), 64'hB6);
      check("np_ck_lo", 64'(gb(25)), 64'h73);
      check("np_b63", 64'(gb(63)), 64'h1E);
      check("np_last_k", 64'(last_k), 64'd74);
      cmp_frame("nopad");

      // Back-to-back with two destination IPs
      pay = {8'h07};
      build(1, MAC_A, IP_A, pay, exp_f);
      dip[0] = IP_A; rv[0] = 1'b1; wait_accept(0);
      collect(0, 0, 0, 1, IP_B, -1);
      cmp_frame("b2b_1");
      build(1, MAC_A, IP_B, pay, exp_f);
      collect(0, 0, 0, 0, IP_A, -1);
      check("b2b_2_first_k", 64'(first_k), 64'd11);
      check("b2b_2_ck_hi", 64'(gb(24)), 64'hB6);
      check("b2b_2_ck_lo", 64'(gb(25)), 64'h8F);
      cmp_frame("b2b_2");
      dip[0] = IP_A;

      // Input isolation
      res1 = 8'h5A; dip[0] = IP_B; dmac[0] = 48'h112233445566;
      pay = {8'h5A};
      build(1, 48'h112233445566, IP_B, pay, exp_f);
      rv[0] = 1'b1; wait_accept(0);
      collect(0, 0, 1, 0, IP_A, -1);
      cmp_frame("iso");
      res1 = 8'h07; dip[0] = IP_A; dmac[0] = MAC_A;

      // Reset at byte 20, then a fresh frame
      rv[0] = 1'b1; wait_accept(0);
      collect(0, 0, 0, 0, IP_A, 20);
      check("reset_hit", 64'(aborted), 64'd1);
      pay = {8'h07};
      build(1, MAC_A, IP_A, pay, exp_f);
      collect(0, 0, 0, 0, IP_A, -1);
      cmp_frame("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ip_packet_tx.md
# ip_packet_tx

Transmit-side counterpart to the accelerator's IP receive path. It accepts one result word from the accelerator together with the requester's IP and MAC addresses. It then builds an Ethernet II + IPv4 frame with a computed header checksum and streams it byte-wide to the MAC's AXI-Stream transmit interface, zero-padding to the Ethernet minimum length. It sits between the accelerator output and the MAC TX FIFO.

## Interface
- RESULT_BYTES, 1, payload bytes per frame (inference result)
- MIN_FRAME_BYTES, 60, minimum frame length excluding FCS; shorter frames are zero-padded
- IP_PROTOCOL, 8'hFD, IPv4 protocol field
- IP_TTL, 8'd64, IPv4 TTL field
- ACLK  in  1  clock
- ARESET  in  1  reset; synchronous, active-high
- ACCELERATOR_IP_ADDRESS  in  [0:31]  source IP written into the header
- ACCELERATOR_MAC_ADDRESS  in  [0:47]  source MAC written into the header
- RESULT_DATA  in  [0:RESULT_BYTES*8-1]  payload; bits [0:7] are the first payload byte on the wire
- DST_IP_ADDRESS  in  [0:31]  destination IP (the requester's source IP)
- DST_MAC_ADDRESS  in  [0:47]  destination MAC (the requester's source MAC)
- RESULT_VALID  in  1  request to send
- RESULT_READY  out  1  block idle and able to accept a request
- MAC_DATA_IN  out  [7:0]  TX byte to MAC
- MAC_DATA_VALID  out  1  TX byte valid
- MAC_DATA_LAST  out  1  final byte of frame
- MAC_DATA_READY  in  1  MAC accepts byte
- TX_BUSY  out  1  debug; high in any state other than IDLE

## Operation
- Frame layout, byte 0 first. All multi-byte fields are MSB-first.
  - Bytes 0-5: DST MAC. Bytes 6-11: ACCELERATOR MAC. Bytes 12-13: 0x0800.
  - Bytes 14-33: IPv4 header with these fields, in order:
    - 0x45, 0x00
    - total length = 20+RESULT_BYTES (16 bit)
    - ID 0x0000, flags/fragment 0x4000
    - IP_TTL, IP_PROTOCOL
    - checksum
    - source IP = ACCELERATOR_IP_ADDRESS, destination IP = DST_IP_ADDRESS
  - Payload follows the IP header, then zero bytes until MIN_FRAME_BYTES total.
  - Frame length = max(34+RESULT_BYTES, MIN_FRAME_BYTES).
- Request capture: on a cycle with RESULT_VALID && RESULT_READY, register RESULT_DATA, DST_IP_ADDRESS, DST_MAC_ADDRESS, ACCELERATOR_IP_ADDRESS and ACCELERATOR_MAC_ADDRESS. The frame uses only these registered copies, so input changes after acceptance do not affect it.
- States:
  - IDLE: RESULT_READY=1. On handshake, go to CHECKSUM.
  - CHECKSUM: 10 cycles, one 16-bit header word per cycle, with the checksum word taken as 0.
    - Accumulator is 16 bits, cleared on entry. Each cycle: sum17 = acc + word; acc = sum17[15:0] + sum17[16] (end-around carry).
    - After word 9, store ~acc as the checksum and go to SEND_HDR.
  - SEND_HDR: bytes 0-33. At byte 33, go to SEND_DATA.
  - SEND_DATA: RESULT_BYTES bytes. At the last payload byte, go to SEND_PAD if padding is needed, else IDLE.
  - SEND_PAD: zero bytes until the frame-length byte, then IDLE.
- Byte counter is 16 bits. It is cleared on entry to SEND_HDR and increments only on MAC_DATA_VALID && MAC_DATA_READY.
- State transitions out of SEND_HDR, SEND_DATA and SEND_PAD happen only on a handshake of the boundary byte.
- MAC_DATA_LAST=1 exactly on byte index frame_length-1.

## Timing
- Reset values: RESULT_READY=1 (IDLE), MAC_DATA_VALID=0, MAC_DATA_LAST=0, MAC_DATA_IN=0, TX_BUSY=0. Internal checksum and counters are 0.
- Latency: handshake at cycle T gives CHECKSUM during T+1..T+10. Byte 0 is valid at T+11. With MAC_DATA_READY held high, one byte per cycle, so the last byte is at T+10+frame_length.
- RESULT_READY falls at T+1 and rises the cycle after the LAST byte is accepted. Back-to-back requests are accepted on that cycle.
- MAC_DATA_VALID, MAC_DATA_IN and MAC_DATA_LAST are registered outputs.
- While MAC_DATA_VALID=1 && MAC_DATA_READY=0, the output holds byte, LAST and VALID unchanged. VALID never drops mid-frame.
- MAC_DATA_READY low for any number of cycles stalls the frame with no byte lost or duplicated. MAC_DATA_READY has no effect in IDLE or CHECKSUM.
- RESULT_VALID asserted while busy is ignored; the requester holds it until RESULT_READY.
- ARESET asserted mid-frame: the next cycle is IDLE with VALID=0. The partial frame is abandoned with no LAST, and the MAC side discards it. No request is accepted in the reset cycle.

## Test plan
- Basic frame: RESULT_BYTES=1, RESULT_DATA=0x07, acc IP C0A8010A, dst IP C0A80101, MAC_DATA_READY=1 -> 60 bytes out.
  - Bytes 12-13 are 08 00, bytes 16-17 are 00 15, bytes 24-25 (checksum) are B6 90, byte 34 is 07, bytes 35-59 are 00.
  - LAST only on byte 59. First byte is 11 cycles after the handshake.
- Backpressure: as the basic frame, but MAC_DATA_READY toggles pseudo-randomly -> identical 60-byte sequence, and outputs are stable during every stall.
- No padding: RESULT_BYTES=30 -> 64 bytes total, total-length field 0x0032, LAST on byte 63, no pad bytes.
- Back-to-back: RESULT_VALID held high with two different DST_IPs -> two complete frames, each with its own correct checksum. The second handshake occurs the cycle after the first LAST is accepted.
- Input isolation: change RESULT_DATA and DST_* every cycle after the handshake -> the frame carries only the values captured at the handshake.
- Reset mid-frame: assert ARESET at byte 20 -> next cycle VALID=0 and RESULT_READY=1. A fresh request then produces a complete, correct frame.
